gray_cnt_gen: RTL and testbench

- Synchronous up/down Gray-code counter; the producer stage directly upstream of gray2bin. Its G output drives gray2bin's G input.
- Holds an internal binary count and registers the matching Gray code. Only one G bit toggles per count step.
- Supports load, direction, and wrap-or-saturate modes, plus terminal-count and change flags for the consumer.

---
 rtl/gray_cnt_gen.sv | 90 +++++++++
 tb/tb_gray_cnt_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gray_cnt_gen.sv
// gray_cnt_gen: up/down Gray-code counter feeding the gray2bin stage.
// A binary count is kept internally. The Gray code is taken from the next
// binary value and registered on the same edge, so G and bin_out always agree.
// A count step changes exactly one bit of G. A load can change several bits.

module gray_cnt_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min,
    output logic             chg
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MIN = '0;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             tc_q, tc_d;
    logic             chg_q, chg_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;

    // Next count: load beats en; the ends either wrap (with tc) or saturate.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                if (bin_q != CNT_MAX) begin
                    bin_d = bin_q + CNT_ONE;
                end else if (wrap_en) begin
                    bin_d = CNT_MIN;
                    tc_d  = 1'b1;
                end
            end else begin
                if (bin_q != CNT_MIN) begin
                    bin_d = bin_q - CNT_ONE;
                end else if (wrap_en) begin
                    bin_d = CNT_MAX;
                    tc_d  = 1'b1;
                end
            end
        end
        g_d      = bin_d ^ (bin_d >> 1);
        chg_d    = (g_d != g_q);
        at_max_d = (bin_d == CNT_MAX);
        at_min_d = (bin_d == CNT_MIN);
    end

    // Register every output; reset takes priority over load and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            g_q      <= '0;
            tc_q     <= 1'b0;
            chg_q    <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            bin_q    <= bin_d;
            g_q      <= g_d;
            tc_q     <= tc_d;
            chg_q    <= chg_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign G       = g_q;
    assign bin_out = bin_q;
    assign tc      = tc_q;
    assign chg     = chg_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;

endmodule

// File: tb/tb_gray_cnt_gen.sv
// Testbench for gray_cnt_gen. A behavioural model pushes the expected outputs
// of each cycle into a queue when the stimulus is driven. The entry is popped
// and compared once the DUT outputs settle after the edge.

module tb_gray_cnt_gen;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] g;
        logic         tc;
        logic         chg;
        logic         amax;
        logic         amin;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en, up, wrap_en, load;
    logic [W-1:0] load_val;
    logic [W-1:0] G, bin_out;
    logic         tc, at_max, at_min, chg;

    int total = 0;
    int bad   = 0;

    exp_t         sb_q[$];
    logic [W-1:0] m_bin = '0;
    logic [W-1:0] m_g   = '0;

    gray_cnt_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .wrap_en(wrap_en),
        .load(load), .load_val(load_val), .G(G), .bin_out(bin_out),
        .tc(tc), .at_max(at_max), .at_min(at_min), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic u, input logic w,
                        input logic l, input logic [W-1:0] lv);
        exp_t         x;
        logic [W-1:0] nb;
        logic         ntc;
        rst = r; en = e; up = u; wrap_en = w; load = l; load_val = lv;
        nb  = m_bin;
        ntc = 1'b0;
        if (r) begin
            nb = '0;
        end else if (l) begin
            nb = lv;
        end else if (e) begin
            if (u) begin
                if (m_bin == 4'd15) begin
                    if (w) begin nb = 4'd0; ntc = 1'b1; end
                end else nb = m_bin + 4'd1;
            end else begin
                if (m_bin == 4'd0) begin
                    if (w) begin nb = 4'd15; ntc = 1'b1; end
                end else nb = m_bin - 4'd1;
            end
        end
        x.bin  = nb;
        x.g    = nb ^ (nb >> 1);
        x.tc   = ntc;
        x.chg  = r ? 1'b0 : (x.g != m_g);
        x.amax = (nb == 4'd15);
        x.amin = (nb == 4'd0);
        m_bin  = nb;
        m_g    = x.g;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb_q.pop_front();
            chk("bin", 32'(bin_out), 32'(x.bin));
            chk("g", 32'(G), 32'(x.g));
            chk("tc", 32'(tc), 32'(x.tc));
            chk("chg", 32'(chg), 32'(x.chg));
            chk("at_max", 32'(at_max), 32'(x.amax));
            chk("at_min", 32'(at_min), 32'(x.amin));
            chk("g2b", 32'(g2b(G)), 32'(x.bin));
        end
    endtask

    initial begin
        logic [W-1:0] gseq[17];
        logic [W-1:0] prev_g;
        gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13,
                 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0, 4'd1};
        rst = 1'b1; en = 1'b0; up = 1'b0; wrap_en = 1'b0; load = 1'b0; load_val = '0;

        // Reset, then count up through a wrap.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_g", 32'(G), 0);
        chk("rst_amin", 32'(at_min), 1);
        prev_g = G;
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 1, 1, 0, 0);
            chk("up_gseq", 32'(G), 32'(gseq[i]));
            chk("up_tc", 32'(tc), (i == 15) ? 1 : 0);
            chk("up_chg", 32'(chg), 1);
            chk("up_onebit", $countones(G ^ prev_g), 1);
            prev_g = G;
        end

        // Count down from 0 with wrap.
        step(0, 0, 0, 0, 1, 4'd0);
        step(0, 1, 0, 1, 0, 0);
        chk("dn_bin0", 32'(bin_out), 15); chk("dn_g0", 32'(G), 8); chk("dn_tc0", 32'(tc), 1);
        step(0, 1, 0, 1, 0, 0);
        chk("dn_bin1", 32'(bin_out), 14); chk("dn_g1", 32'(G), 9); chk("dn_tc1", 32'(tc), 0);
        step(0, 1, 0, 1, 0, 0);
        chk("dn_bin2", 32'(bin_out), 13); chk("dn_g2", 32'(G), 11);

        // Load overrides en; reloading the same value shows no change.
        step(0, 1, 1, 1, 1, 4'd10);
        chk("ld_bin", 32'(bin_out), 10); chk("ld_g", 32'(G), 15);
        chk("ld_tc", 32'(tc), 0); chk("ld_chg", 32'(chg), 1);
        step(0, 0, 0, 1, 1, 4'd10);
        chk("ld_same_chg", 32'(chg), 0);

        // Saturate at max, then step down once.
        step(0, 0, 1, 0, 1, 4'd15);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("sat_bin", 32'(bin_out), 15); chk("sat_g", 32'(G), 8);
            chk("sat_amax", 32'(at_max), 1); chk("sat_tc", 32'(tc), 0);
            chk("sat_chg", 32'(chg), 0);
        end
        step(0, 1, 0, 0, 0, 0);
        chk("sat_dn_bin", 32'(bin_out), 14); chk("sat_dn_g", 32'(G), 9);
        chk("sat_dn_amax", 32'(at_max), 0);

        // Saturate at min.
        step(0, 0, 0, 0, 1, 4'd0);
        step(0, 1, 0, 0, 0, 0);
        chk("satmin_bin", 32'(bin_out), 0); chk("satmin_chg", 32'(chg), 0);

        // Reset mid-count with en and load also high.
        step(0, 0, 0, 1, 1, 4'd5);
        step(0, 1, 1, 1, 0, 0);
        chk("mid_bin6", 32'(bin_out), 6);
        step(1, 1, 1, 1, 1, 4'd9);
        chk("mid_bin", 32'(bin_out), 0); chk("mid_g", 32'(G), 0);
        chk("mid_chg", 32'(chg), 0); chk("mid_amin", 32'(at_min), 1);
        step(0, 1, 1, 1, 0, 0); chk("resume_g1", 32'(G), 1);
        step(0, 1, 1, 1, 0, 0); chk("resume_g3", 32'(G), 3);
        step(0, 1, 1, 1, 0, 0); chk("resume_g2", 32'(G), 2);

        // Idle hold at 7.
        step(0, 0, 0, 0, 1, 4'd7);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);
            chk("idle_g", 32'(G), 4); chk("idle_chg", 32'(chg), 0); chk("idle_tc", 32'(tc), 0);
        end

        // Random mix, checked against the model only.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
